// File: rtl/id_pkg.sv
// Shared types and constants for the identifier scanner and later lexer stages.
package id_pkg;

    // Scanner FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IDENT = 2'd1,
        BAD   = 2'd2
    } state_t;

    // Character classes: separator, letter, digit.
    typedef enum logic [1:0] {
        CL_S = 2'd0,
        CL_L = 2'd1,
        CL_D = 2'd2
    } cls_t;

    // ASCII range bounds.
    localparam logic [7:0] ASCII_UPPER_LO = 8'h41;  // 'A'
    localparam logic [7:0] ASCII_UPPER_HI = 8'h5A;  // 'Z'
    localparam logic [7:0] ASCII_LOWER_LO = 8'h61;  // 'a'
    localparam logic [7:0] ASCII_LOWER_HI = 8'h7A;  // 'z'
    localparam logic [7:0] ASCII_DIGIT_LO = 8'h30;  // '0'
    localparam logic [7:0] ASCII_DIGIT_HI = 8'h39;  // '9'
    localparam logic [7:0] ASCII_US       = 8'h5F;  // '_'

    // True when c lies inside the closed range [lo, hi].
    function automatic logic in_range(input logic [7:0] c, input logic [7:0] lo,
                                      input logic [7:0] hi);
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/id_char_class.sv
// Combinational ASCII classifier: letter / digit / separator.
module id_char_class
    import id_pkg::*;
#(
    parameter int unsigned ALLOW_US = 1
) (
    input  logic [7:0] char,
    output cls_t       char_class
);

    logic is_letter;
    logic is_digit;

    // Decode the character into one of the three classes.
    always_comb begin
        is_letter = in_range(char, ASCII_UPPER_LO, ASCII_UPPER_HI) ||
                    in_range(char, ASCII_LOWER_LO, ASCII_LOWER_HI) ||
                    ((ALLOW_US != 0) && (char == ASCII_US));
        is_digit  = in_range(char, ASCII_DIGIT_LO, ASCII_DIGIT_HI);
        char_class = CL_S;
        if (is_letter) begin
            char_class = CL_L;
        end else if (is_digit) begin
            char_class = CL_D;
        end
    end

endmodule

// File: rtl/id_scanner.sv
// Identifier token scanner: tracks letter-first alphanumeric runs in a character
// stream, reporting match state, length, completion/error pulses and a token count.
module id_scanner
    import id_pkg::*;
#(
    parameter int unsigned MAX_LEN  = 8,
    parameter int unsigned LEN_W    = 4,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned ALLOW_US = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char,
    input  logic             in_valid,
    output logic             out,
    output logic [LEN_W-1:0] len,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] count
);

    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] COUNT_SAT = {CNT_W{1'b1}};

    cls_t             cls;
    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    id_char_class #(
        .ALLOW_US(ALLOW_US)
    ) u_char_class (
        .char      (char),
        .char_class(cls)
    );

    // Next-state: advance only on qualified characters; pulses default low.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (cls == CL_L) begin
                        state_d = IDENT;
                        len_d   = LEN_W'(1);
                    end else if (cls == CL_D) begin
                        state_d = BAD;
                        err_d   = 1'b1;
                    end
                end
                IDENT: begin
                    if (cls == CL_S) begin
                        state_d = IDLE;
                        len_d   = '0;
                        done_d  = 1'b1;
                        if (count_q != COUNT_SAT) begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end else if (len_q == LEN_MAX) begin
                        // One character too many: the whole run becomes an error token.
                        state_d = BAD;
                        len_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        len_d = len_q + LEN_W'(1);
                    end
                end
                BAD: begin
                    if (cls == CL_S) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    len_d   = '0;
                end
            endcase
        end
    end

    // State, length, counter and pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign out   = (state_q == IDENT);
    assign len   = len_q;
    assign done  = done_q;
    assign err   = err_q;
    assign count = count_q;

endmodule

// File: tb/tb_id_scanner.sv
// Bench for id_scanner: a default instance and a small instance
// (MAX_LEN=4, CNT_W=2, ALLOW_US=0) share one character stream.
module tb_id_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ch  = 8'h00;
    logic       vld = 1'b0;

    logic       out0, done0, err0;
    logic [3:0] len0;
    logic [7:0] count0;
    logic       out1, done1, err1;
    logic [2:0] len1;
    logic [1:0] count1;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_scanner #(
        .MAX_LEN(8), .LEN_W(4), .CNT_W(8), .ALLOW_US(1)
    ) dut0 (
        .clk(clk), .reset(rst), .char(ch), .in_valid(vld),
        .out(out0), .len(len0), .done(done0), .err(err0), .count(count0)
    );

    id_scanner #(
        .MAX_LEN(4), .LEN_W(3), .CNT_W(2), .ALLOW_US(0)
    ) dut1 (
        .clk(clk), .reset(rst), .char(ch), .in_valid(vld),
        .out(out1), .len(len1), .done(done1), .err(err1), .count(count1)
    );

    // Reference model: token described by its length and whether it began with a letter.
    int unsigned m_maxl[2] = '{8, 4};
    int unsigned m_cmax[2] = '{255, 3};
    bit          m_us[2]   = '{1'b1, 1'b0};
    int unsigned m_tlen[2];
    bit          m_first_l[2];
    int unsigned m_cnt[2];
    bit          m_done[2];
    bit          m_err[2];

    function automatic bit is_letter(int k, logic [7:0] c);
        return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A) ||
               (m_us[k] && c == 8'h5F);
    endfunction

    function automatic bit is_digit(logic [7:0] c);
        return c >= 8'h30 && c <= 8'h39;
    endfunction

    function automatic bit m_out(int k);
        return m_tlen[k] > 0 && m_first_l[k] && m_tlen[k] <= m_maxl[k];
    endfunction

    function automatic logic [14:0] exp_snap(int k);
        int unsigned l;
        l = m_out(k) ? m_tlen[k] : 0;
        return {m_out(k), l[3:0], m_done[k], m_err[k], m_cnt[k][7:0]};
    endfunction

    function automatic logic [14:0] obs_snap(int k);
        if (k == 0) return {out0, len0, done0, err0, count0};
        return {out1, 1'b0, len1, done1, err1, 6'b0, count1};
    endfunction

    task automatic model_step(logic [7:0] c, bit v, bit r);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                m_tlen[k] = 0; m_first_l[k] = 0; m_cnt[k] = 0;
                m_done[k] = 0; m_err[k] = 0;
            end else begin
                m_done[k] = 0;
                m_err[k]  = 0;
                if (v) begin
                    if (!is_letter(k, c) && !is_digit(c)) begin
                        if (m_out(k)) begin
                            m_done[k] = 1;
                            if (m_cnt[k] < m_cmax[k]) m_cnt[k]++;
                        end
                        m_tlen[k] = 0;
                    end else begin
                        if (m_tlen[k] == 0) m_first_l[k] = is_letter(k, c);
                        m_tlen[k]++;
                        if (m_tlen[k] == 1 && !m_first_l[k]) m_err[k] = 1;
                        if (m_first_l[k] && m_tlen[k] == m_maxl[k] + 1) m_err[k] = 1;
                    end
                end
            end
        end
    endtask

    // Present one input set, clock it, update the model, settle past the edge.
    task automatic drive(logic [7:0] c, bit v, bit r);
        ch = c; vld = v; rst = r;
        @(posedge clk);
        model_step(c, v, r);
        #1;
    endtask

    task automatic test_reset();
        drive(8'h00, 1'b0, 1'b1);
        drive(8'h41, 1'b1, 1'b1);
        n_chk++;
        if ({out0, len0, done0, err0, count0} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_dut0: got %h required 0", {out0, len0, done0, err0, count0});
        end
        n_chk++;
        if ({out1, len1, done1, err1, count1} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_dut1: got %h required 0", {out1, len1, done1, err1, count1});
        end
    endtask

    task automatic test_basic();
        logic [7:0] s [5] = '{8'h41, 8'h61, 8'h30, 8'h39, 8'h24};  // "Aa09$"
        int         exp_len [5] = '{1, 2, 3, 4, 0};
        for (int i = 0; i < 5; i++) begin
            drive(s[i], 1'b1, 1'b0);
            n_chk++;
            if (len0 !== 4'(exp_len[i]) || out0 !== (i < 4) || done0 !== (i == 4)) begin
                n_fail++;
                $display("FAIL basic_step%0d: got len=%0d out=%b done=%b required len=%0d",
                         i, len0, out0, done0, exp_len[i]);
            end
        end
        n_chk++;
        if (count0 !== 8'd1) begin
            n_fail++;
            $display("FAIL basic_count: got %0d required 1", count0);
        end
        drive(8'h20, 1'b0, 1'b0);
        n_chk++;
        if (done0 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_clear: got %b required 0", done0);
        end
    endtask

    task automatic test_digit_first();
        logic [7:0] s [3] = '{8'h35, 8'h75, 8'h24};  // "5u$"
        for (int i = 0; i < 3; i++) begin
            drive(s[i], 1'b1, 1'b0);
            n_chk++;
            if (err0 !== (i == 0) || out0 !== 1'b0 || done0 !== 1'b0 || count0 !== 8'd1) begin
                n_fail++;
                $display("FAIL digit_first_step%0d: got err=%b out=%b done=%b count=%0d",
                         i, err0, out0, done0, count0);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] s [6] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h20};  // "abcde "
        drive(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive(s[i], 1'b1, 1'b0);
            if (i < 4) begin
                n_chk++;
                if (len1 !== 3'(i + 1) || out1 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL overflow_len%0d: got %0d required %0d", i, len1, i + 1);
                end
            end else if (i == 4) begin
                n_chk++;
                if (err1 !== 1'b1 || out1 !== 1'b0 || len1 !== 3'd0) begin
                    n_fail++;
                    $display("FAIL overflow_err: got err=%b out=%b len=%0d", err1, out1, len1);
                end
            end else begin
                n_chk++;
                if (done1 !== 1'b0 || count1 !== 2'd0 || err1 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL overflow_sep: got done=%b count=%0d required 0 0",
                             done1, count1);
                end
            end
        end
        // Exactly MAX_LEN characters is still a valid identifier.
        for (int i = 0; i < 4; i++) drive(s[i], 1'b1, 1'b0);
        drive(8'h20, 1'b1, 1'b0);
        n_chk++;
        if (done1 !== 1'b1 || count1 !== 2'd1) begin
            n_fail++;
            $display("FAIL exact_max_len: got done=%b count=%0d required 1 1", done1, count1);
        end
    endtask

    task automatic test_stall();
        drive(8'h00, 1'b0, 1'b1);
        drive(8'h78, 1'b1, 1'b0);  // 'x'
        for (int i = 0; i < 3; i++) begin
            drive(8'h31, 1'b0, 1'b0);
            n_chk++;
            if (out0 !== 1'b1 || len0 !== 4'd1 || done0 !== 1'b0 || err0 !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got out=%b len=%0d done=%b err=%b",
                         i, out0, len0, done0, err0);
            end
        end
        drive(8'h31, 1'b1, 1'b0);
        n_chk++;
        if (len0 !== 4'd2) begin
            n_fail++;
            $display("FAIL stall_resume: got len=%0d required 2", len0);
        end
        drive(8'h20, 1'b1, 1'b0);
        n_chk++;
        if (done0 !== 1'b1 || count0 !== 8'd1) begin
            n_fail++;
            $display("FAIL stall_done: got done=%b count=%0d required 1 1", done0, count0);
        end
    endtask

    task automatic test_reset_mid_token();
        drive(8'h00, 1'b0, 1'b1);
        drive(8'h61, 1'b1, 1'b0);
        drive(8'h62, 1'b1, 1'b0);
        drive(8'h20, 1'b1, 1'b1);
        n_chk++;
        if ({out0, len0, done0, err0, count0} !== 15'd0 ||
            {out1, len1, done1, err1, count1} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid_token: got %h / %h required 0",
                     {out0, len0, done0, err0, count0}, {out1, len1, done1, err1, count1});
        end
        drive(8'h5F, 1'b1, 1'b0);  // '_'
        n_chk++;
        if (out0 !== 1'b1 || out1 !== 1'b0) begin
            n_fail++;
            $display("FAIL underscore_class: got out0=%b out1=%b required 1 0", out0, out1);
        end
        drive(8'h71, 1'b1, 1'b0);  // 'q'
        n_chk++;
        if (len0 !== 4'd2 || len1 !== 3'd1 || out1 !== 1'b1) begin
            n_fail++;
            $display("FAIL underscore_len: got len0=%0d len1=%0d required 2 1", len0, len1);
        end
        drive(8'h20, 1'b1, 1'b0);
        n_chk++;
        if (done0 !== 1'b1 || done1 !== 1'b1 || count0 !== 8'd1 || count1 !== 2'd1) begin
            n_fail++;
            $display("FAIL underscore_done: got done=%b%b count=%0d/%0d required 11 1/1",
                     done0, done1, count0, count1);
        end
    endtask

    task automatic test_saturate();
        int exp_cnt;
        drive(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(8'h61, 1'b1, 1'b0);
            drive(8'h20, 1'b1, 1'b0);
            exp_cnt = (i + 1 > 3) ? 3 : i + 1;
            n_chk++;
            if (done1 !== 1'b1 || count1 !== 2'(exp_cnt) || count0 !== 8'(i + 1)) begin
                n_fail++;
                $display("FAIL saturate%0d: got done=%b count1=%0d count0=%0d required 1 %0d %0d",
                         i, done1, count1, count0, exp_cnt, i + 1);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] c;
        bit         v, r;
        int         sel;
        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1:    c = 8'($urandom_range(8'h61, 8'h7A));
                2, 3:    c = 8'($urandom_range(8'h41, 8'h5A));
                4, 5:    c = 8'($urandom_range(8'h30, 8'h39));
                6:       c = 8'h5F;
                7:       c = 8'h20;
                8:       c = 8'h24;
                default: c = 8'($urandom_range(0, 255));
            endcase
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 249) == 0);
            drive(c, v, r);
            for (int k = 0; k < 2; k++) begin
                n_chk++;
                if (obs_snap(k) !== exp_snap(k)) begin
                    n_fail++;
                    $display("FAIL random_dut%0d cycle %0d char=%h valid=%b: got %h required %h",
                             k, n, c, v, obs_snap(k), exp_snap(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_digit_first();
        test_overflow();
        test_stall();
        test_reset_mid_token();
        test_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/id_scanner.md
Name: id_scanner

Overview:
- Parametrised successor to the single-bit identifier recogniser `id_fsm`.
- Consumes one 8-bit ASCII character per qualified clock and tracks identifier tokens (letter first, then letters/digits) in a continuous character stream.
- Reports current match state, token length, completed-token pulses, error pulses and a running token count.
- Sits behind the character source in the P1 lexer datapath.

Parameters:
- MAX_LEN, 8: maximum identifier length in characters; a longer run is an error token.
- LEN_W, 4: width of len; must satisfy 2^LEN_W > MAX_LEN.
- CNT_W, 8: width of the completed-identifier counter.
- ALLOW_US, 1: when 1, '_' (0x5F) is treated as a letter; when 0, it is a separator.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- char  in  8  ASCII character.
- in_valid  in  1  char is consumed on this edge when 1.
- out  out  1  1 while the characters consumed so far form a valid, unfinished identifier.
- len  out  LEN_W  length of the current identifier; 0 outside IDENT.
- done  out  1  one-cycle pulse: an identifier was terminated by a separator.
- err  out  1  one-cycle pulse: an invalid token started (digit first, or length overflow).
- count  out  CNT_W  number of completed identifiers; saturates at all-ones.

Behaviour:
- Reset and clocking
  - One clock (clk); reset is synchronous and active-high (reset).
  - On reset: state=IDLE, out=0, len=0, done=0, err=0, count=0.
  - reset has priority over in_valid.
  - Reset mid-token discards the token: no done, count unchanged from its cleared value.
- Character classes (combinational, from char)
  - L: 'A'-'Z' (0x41-0x5A), 'a'-'z' (0x61-0x7A), and '_' when ALLOW_US=1.
  - D: '0'-'9' (0x30-0x39).
  - S: everything else, including 0x00, space and '$'.
- States: IDLE, IDENT, BAD. Transitions happen only on edges where in_valid=1.
  - IDLE: L -> IDENT, len=1. D -> BAD, err=1. S -> IDLE.
  - IDENT: L/D with len<MAX_LEN -> IDENT, len+1.
  - IDENT: L/D with len==MAX_LEN -> BAD, err=1, len=0.
  - IDENT: S -> IDLE, done=1, len=0, count+1 (saturating).
  - BAD: L/D -> BAD. S -> IDLE. No done, no count change.
- Output timing
  - All outputs are registered.
  - out = (state==IDENT), updated on the same edge that consumes the character, so it is visible one cycle after char is presented.
  - done and err are high for exactly the cycle following the triggering edge, and cleared on every other edge.
  - An in_valid=0 edge holds state, len and count, and clears done/err.
- Boundary conditions
  - A separator immediately after a separator is a no-op.
  - An identifier of exactly MAX_LEN characters followed by S is valid: done=1, count increments.
  - Once count reaches 2^CNT_W-1 it holds; done still pulses.
  - ALLOW_US=0: '_' inside IDENT terminates the token (done pulse).
  - There is no end-of-stream flush: an identifier still open when in_valid stops remains in IDENT with out=1.

Decomposition:
- Package id_pkg holds:
  - state encoding IDLE=2'd0, IDENT=2'd1, BAD=2'd2;
  - class encoding CL_S=2'd0, CL_L=2'd1, CL_D=2'd2;
  - ASCII range constants.
- Sub-module id_char_class: purely combinational, char[7:0] + ALLOW_US -> class[1:0]. It is reused by later lexer stages.
- The top holds the FSM, the len register, the count register and the pulse registers.

Test Plan:
1. Defaults. reset=1 for 2 cycles, then the stream "A","a","0","9","$" one per cycle with in_valid=1.
   -> out=1 after 'A' through '9'; len steps 1,2,3,4; after '$': out=0, done=1 for one cycle, count=1, len=0.
2. Stream "5","u","$".
   -> err=1 for one cycle after '5'; out stays 0 throughout; no done; count unchanged.
3. MAX_LEN=4, stream "a","b","c","d","e"," ".
   -> len 1..4; after 'e': err=1, out=0, len=0; after ' ': no done, count=0.
   - Same run with "abcd " instead -> done=1, count=1.
4. Stream "x", then in_valid=0 for 3 cycles, then "1"," ".
   -> out=1 and len=1 held across the stall; done/err stay 0 during the stall; len=2 after '1'; done after ' ', count=1.
5. Stream "ab", then reset=1 for one cycle on the edge where char=" ".
   -> all outputs 0, no done pulse.
   - Then "_q " with ALLOW_US=1 -> done, count=1.
   - With ALLOW_US=0 -> no identifier until 'q'; done after ' '.
6. CNT_W=2, five identifiers "a " repeated.
   -> count 1,2,3,3,3; done pulses five times.
